// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// instruction classes, opcode map and ALU control codes.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_ALU   = 4'd7,
      S_WB_MEM   = 4'd8,
      S_BRANCH   = 4'd9,
      S_HALT     = 4'd10
   } state_t;

   typedef enum logic [2:0] {
      CLS_NOP  = 3'd0,
      CLS_R    = 3'd1,
      CLS_ADDI = 3'd2,
      CLS_LW   = 3'd3,
      CLS_SW   = 3'd4,
      CLS_BEQ  = 3'd5,
      CLS_BNE  = 3'd6,
      CLS_HALT = 3'd7
   } iclass_t;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_ADDI = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_LW   = 4'b0110;
   localparam logic [3:0] OP_SW   = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_BNE  = 4'b1001;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   // Retired-instruction counter sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode decoder: instruction class plus the ALU operation
// that class uses in its execute/address/compare step.
module mc_decode
   import multicycle_control_pkg::*;
(
   input  logic [3:0] opcode,
   output iclass_t    iclass,
   output logic [3:0] alu_control
);

   always_comb begin
      iclass      = CLS_NOP;
      alu_control = 4'b0000;
      case (opcode)
         OP_ADD:  begin iclass = CLS_R;    alu_control = ALU_ADD; end
         OP_ADDI: begin iclass = CLS_ADDI; alu_control = ALU_ADD; end
         OP_SUB:  begin iclass = CLS_R;    alu_control = ALU_SUB; end
         OP_AND:  begin iclass = CLS_R;    alu_control = ALU_AND; end
         OP_OR:   begin iclass = CLS_R;    alu_control = ALU_OR;  end
         OP_SLT:  begin iclass = CLS_R;    alu_control = ALU_SLT; end
         OP_LW:   begin iclass = CLS_LW;   alu_control = ALU_ADD; end
         OP_SW:   begin iclass = CLS_SW;   alu_control = ALU_ADD; end
         OP_BEQ:  begin iclass = CLS_BEQ;  alu_control = ALU_SUB; end
         OP_BNE:  begin iclass = CLS_BNE;  alu_control = ALU_SUB; end
         OP_HALT: begin iclass = CLS_HALT; alu_control = 4'b0000; end
         default: begin iclass = CLS_NOP;  alu_control = 4'b0000; end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: fetch/decode/execute FSM with memory
// wait states, a latched instruction class and a saturating retire counter.
module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_source,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        alu_src,
   output logic [3:0]  alu_control,
   output logic        halted,
   output logic [15:0] retired,
   output logic [3:0]  debug_state
);

   state_t     state_q, state_d;
   iclass_t    cls_q, dec_cls;
   logic [3:0] alu_q, dec_alu;
   logic [15:0] retired_q;
   logic       retire;

   logic mr_c, mw_c, irw_c, pcw_c, pcs_c, rw_c, m2r_c, asrc_c;
   logic [3:0] alu_c;

   mc_decode u_decode (
      .opcode      (opcode),
      .iclass      (dec_cls),
      .alu_control (dec_alu)
   );

   // The class and ALU op are captured in DECODE so later opcode changes
   // cannot disturb the instruction in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         cls_q     <= CLS_NOP;
         alu_q     <= 4'b0000;
         retired_q <= 16'd0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            cls_q <= dec_cls;
            alu_q <= dec_alu;
         end
         if (retire)
            retired_q <= sat_inc(retired_q);
      end
   end

   // mem_ready qualifies the current request: an access in FETCH, MEM_RD or
   // MEM_WR completes in the cycle mem_ready is 1; otherwise the state holds.
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      mr_c    = 1'b0;
      mw_c    = 1'b0;
      irw_c   = 1'b0;
      pcw_c   = 1'b0;
      pcs_c   = 1'b0;
      rw_c    = 1'b0;
      m2r_c   = 1'b0;
      asrc_c  = 1'b0;
      alu_c   = 4'b0000;
      case (state_q)
         S_FETCH: begin
            mr_c = 1'b1;
            if (mem_ready) begin
               irw_c   = 1'b1;
               pcw_c   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (dec_cls)
               CLS_R:          state_d = S_EXEC_R;
               CLS_ADDI:       state_d = S_EXEC_I;
               CLS_LW, CLS_SW: state_d = S_MEM_ADDR;
               CLS_BEQ, CLS_BNE: state_d = S_BRANCH;
               CLS_HALT: begin
                  state_d = S_HALT;
                  retire  = 1'b1;
               end
               default: begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
            endcase
         end
         S_EXEC_R: begin
            alu_c   = alu_q;
            state_d = S_WB_ALU;
         end
         S_EXEC_I: begin
            asrc_c  = 1'b1;
            alu_c   = ALU_ADD;
            state_d = S_WB_ALU;
         end
         S_WB_ALU: begin
            rw_c    = 1'b1;
            asrc_c  = (cls_q == CLS_ADDI);
            alu_c   = alu_q;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_MEM_ADDR: begin
            asrc_c  = 1'b1;
            alu_c   = ALU_ADD;
            state_d = (cls_q == CLS_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mr_c = 1'b1;
            if (mem_ready)
               state_d = S_WB_MEM;
         end
         S_WB_MEM: begin
            rw_c    = 1'b1;
            m2r_c   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_MEM_WR: begin
            mw_c = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_BRANCH: begin
            alu_c   = ALU_SUB;
            pcs_c   = 1'b1;
            pcw_c   = ((cls_q == CLS_BEQ) & zero) | ((cls_q == CLS_BNE) & ~zero);
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // Outputs are gated so reset silences them in the same cycle it rises.
   assign mem_read    = mr_c  & ~reset;
   assign mem_write   = mw_c  & ~reset;
   assign ir_write    = irw_c & ~reset;
   assign pc_write    = pcw_c & ~reset;
   assign pc_source   = pcs_c & ~reset;
   assign reg_write   = rw_c  & ~reset;
   assign mem_to_reg  = m2r_c & ~reset;
   assign alu_src     = asrc_c & ~reset;
   assign alu_control = reset ? 4'b0000 : alu_c;
   assign halted      = (state_q == S_HALT) & ~reset;
   assign retired     = retired_q;
   assign debug_state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction cycle plans
// from the opcode table, randomized waits and inputs, scoreboard queues.
module tb_multicycle_control;
   import multicycle_control_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  opcode = 4'h0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_read, mem_write, ir_write, pc_write, pc_source;
   logic        reg_write, mem_to_reg, alu_src, halted;
   logic [3:0]  alu_control, debug_state;
   logic [15:0] retired;

   multicycle_control dut (
      .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
      .alu_control(alu_control), .halted(halted), .retired(retired),
      .debug_state(debug_state)
   );

   always #5 clock = ~clock;

   logic [11:0] obs;
   assign obs = {mem_read, mem_write, ir_write, pc_write, pc_source,
                 reg_write, mem_to_reg, alu_src, alu_control};

   logic [11:0] exp_q[$];
   logic [3:0]  st_q[$];
   logic        rdy_q[$];
   logic [3:0]  opc_q[$];
   logic        zero_q[$];

   int errors = 0;
   int checks = 0;
   logic [15:0] retired_model = 16'd0;

   function automatic logic [11:0] pk(input logic mr, input logic mw, input logic irw,
                                      input logic pcw, input logic pcs, input logic rw,
                                      input logic m2r, input logic asrc, input logic [3:0] alu);
      return {mr, mw, irw, pcw, pcs, rw, m2r, asrc, alu};
   endfunction

   function automatic logic [3:0] alu_of(input logic [3:0] op);
      case (op)
         4'h0: return 4'b0010;
         4'h2: return 4'b0110;
         4'h3: return 4'b0000;
         4'h4: return 4'b0001;
         4'h5: return 4'b0111;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic push(input logic [11:0] o, input state_t s, input logic rdy,
                       input logic [3:0] opc, input logic z);
      exp_q.push_back(o);
      st_q.push_back(s);
      rdy_q.push_back(rdy);
      opc_q.push_back(opc);
      zero_q.push_back(z);
   endtask

   // Build the cycle-by-cycle expectation for one instruction starting in FETCH.
   task automatic plan_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
      for (int i = 0; i < fw; i++)
         push(pk(1,0,0,0,0,0,0,0,4'h0), S_FETCH, 1'b0, 4'($urandom), 1'($urandom));
      push(pk(1,0,1,1,0,0,0,0,4'h0), S_FETCH, 1'b1, 4'($urandom), 1'($urandom));
      push(12'h000, S_DECODE, 1'($urandom), op, 1'($urandom));
      case (op)
         4'h0, 4'h2, 4'h3, 4'h4, 4'h5: begin
            push(pk(0,0,0,0,0,0,0,0,alu_of(op)), S_EXEC_R, 1'($urandom), 4'($urandom), 1'($urandom));
            push(pk(0,0,0,0,0,1,0,0,alu_of(op)), S_WB_ALU, 1'($urandom), 4'($urandom), 1'($urandom));
         end
         4'h1: begin
            push(pk(0,0,0,0,0,0,0,1,4'b0010), S_EXEC_I, 1'($urandom), 4'($urandom), 1'($urandom));
            push(pk(0,0,0,0,0,1,0,1,4'b0010), S_WB_ALU, 1'($urandom), 4'($urandom), 1'($urandom));
         end
         4'h6: begin
            push(pk(0,0,0,0,0,0,0,1,4'b0010), S_MEM_ADDR, 1'($urandom), 4'($urandom), 1'($urandom));
            for (int i = 0; i < mw; i++)
               push(pk(1,0,0,0,0,0,0,0,4'h0), S_MEM_RD, 1'b0, 4'($urandom), 1'($urandom));
            push(pk(1,0,0,0,0,0,0,0,4'h0), S_MEM_RD, 1'b1, 4'($urandom), 1'($urandom));
            push(pk(0,0,0,0,0,1,1,0,4'h0), S_WB_MEM, 1'($urandom), 4'($urandom), 1'($urandom));
         end
         4'h7: begin
            push(pk(0,0,0,0,0,0,0,1,4'b0010), S_MEM_ADDR, 1'($urandom), 4'($urandom), 1'($urandom));
            for (int i = 0; i < mw; i++)
               push(pk(0,1,0,0,0,0,0,0,4'h0), S_MEM_WR, 1'b0, 4'($urandom), 1'($urandom));
            push(pk(0,1,0,0,0,0,0,0,4'h0), S_MEM_WR, 1'b1, 4'($urandom), 1'($urandom));
         end
         4'h8, 4'h9: begin
            push(pk(0,0,0,(op == 4'h8) ? z : ~z,1,0,0,0,4'b0110), S_BRANCH,
                 1'($urandom), 4'($urandom), z);
         end
         default: ;
      endcase
      if (retired_model != 16'hFFFF)
         retired_model = retired_model + 16'd1;
   endtask

   task automatic run_plan(input string name);
      logic [11:0] e;
      logic [3:0]  s;
      int cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clock);
         mem_ready = rdy_q.pop_front();
         opcode    = opc_q.pop_front();
         zero      = zero_q.pop_front();
         e = exp_q.pop_front();
         s = st_q.pop_front();
         #1;
         checks++;
         if (obs !== e)
            $display("FAIL %s outputs cyc %0d: got %h expected %h", name, cyc, obs, e);
         if (obs !== e) errors++;
         checks++;
         if (debug_state !== s) begin
            errors++;
            $display("FAIL %s state cyc %0d: got %0d expected %0d", name, cyc, debug_state, s);
         end
         checks++;
         if (halted !== 1'b0) begin
            errors++;
            $display("FAIL %s halted cyc %0d: got %b expected 0", name, cyc, halted);
         end
         cyc++;
      end
   endtask

   task automatic check_idle(input string name);
      @(negedge clock);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (retired !== retired_model) begin
         errors++;
         $display("FAIL %s retired: got %h expected %h", name, retired, retired_model);
      end
      checks++;
      if (debug_state !== S_FETCH) begin
         errors++;
         $display("FAIL %s idle state: got %0d expected %0d", name, debug_state, S_FETCH);
      end
   endtask

   // Assert reset mid-cycle, check the immediate effect, release at negedge.
   task automatic pulse_reset(input string name);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (obs !== 12'h000 || halted !== 1'b0) begin
         errors++;
         $display("FAIL %s reset outputs: got %h/%b expected 000/0", name, obs, halted);
      end
      checks++;
      if (retired !== 16'd0 || debug_state !== S_FETCH) begin
         errors++;
         $display("FAIL %s reset state: got %h/%0d expected 0000/%0d", name, retired, debug_state, S_FETCH);
      end
      retired_model = 16'd0;
      @(negedge clock);
      reset = 1'b0;
      mem_ready = 1'b0;
      #1;
      checks++;
      if (obs !== pk(1,0,0,0,0,0,0,0,4'h0)) begin
         errors++;
         $display("FAIL %s first fetch: got %h expected %h", name, obs, pk(1,0,0,0,0,0,0,0,4'h0));
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      #1;
      checks++;
      if (obs !== 12'h000 || halted !== 1'b0 || retired !== 16'd0) begin
         errors++;
         $display("FAIL reset_hold: got %h/%b/%h expected 000/0/0000", obs, halted, retired);
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if (obs !== pk(1,0,0,0,0,0,0,0,4'h0) || debug_state !== S_FETCH) begin
         errors++;
         $display("FAIL reset_release: got %h/%0d expected %h/%0d", obs, debug_state,
                  pk(1,0,0,0,0,0,0,0,4'h0), S_FETCH);
      end
   endtask

   task automatic test_add();
      plan_instr(4'h0, 1'b0, 0, 0);
      run_plan("add");
      check_idle("add");
   endtask

   task automatic test_lw_wait();
      plan_instr(4'h6, 1'b0, 0, 3);
      run_plan("lw_wait");
      check_idle("lw_wait");
      plan_instr(4'h7, 1'b1, 2, 2);
      run_plan("sw_wait");
      check_idle("sw_wait");
   endtask

   task automatic test_branch();
      plan_instr(4'h8, 1'b1, 0, 0); run_plan("beq_taken");
      plan_instr(4'h8, 1'b0, 0, 0); run_plan("beq_not");
      plan_instr(4'h9, 1'b0, 0, 0); run_plan("bne_taken");
      plan_instr(4'h9, 1'b1, 0, 0); run_plan("bne_not");
      check_idle("branch");
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         plan_instr(4'($urandom_range(0, 14)), 1'($urandom), $urandom_range(0, 2),
                    $urandom_range(0, 3));
         run_plan("random");
      end
      check_idle("random");
   endtask

   task automatic test_halt();
      plan_instr(4'hF, 1'b0, 1, 0);
      run_plan("halt_entry");
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         mem_ready = 1'($urandom);
         opcode    = 4'($urandom);
         zero      = 1'($urandom);
         #1;
         checks++;
         if (halted !== 1'b1 || obs !== 12'h000 || debug_state !== S_HALT
             || retired !== retired_model) begin
            errors++;
            $display("FAIL halt_hold cyc %0d: got %b/%h/%0d/%h expected 1/000/%0d/%h",
                     i, halted, obs, debug_state, retired, S_HALT, retired_model);
         end
      end
      pulse_reset("halt_reset");
   endtask

   task automatic test_store_reset();
      plan_instr(4'h7, 1'b0, 0, 6);
      while (exp_q.size() > 5) begin
         void'(exp_q.pop_back()); void'(st_q.pop_back()); void'(rdy_q.pop_back());
         void'(opc_q.pop_back()); void'(zero_q.pop_back());
      end
      run_plan("store_wait");
      @(negedge clock);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (mem_write !== 1'b1) begin
         errors++;
         $display("FAIL store_pending: got mem_write=%b expected 1", mem_write);
      end
      pulse_reset("store_reset");
      plan_instr(4'h2, 1'b0, 0, 0);
      run_plan("after_reset");
      check_idle("after_reset");
   endtask

   task automatic test_saturate();
      @(negedge clock);
      force dut.retired_q = 16'hFFFF;
      #1 release dut.retired_q;
      retired_model = 16'hFFFF;
      plan_instr(4'h1, 1'b0, 0, 0);
      run_plan("sat_addi");
      check_idle("sat_addi");
      plan_instr(4'hC, 1'b0, 0, 0);
      run_plan("sat_nop");
      check_idle("sat_nop");
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_wait();
      test_branch();
      test_random();
      test_store_reset();
      test_halt();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
